// File: rtl/pc_pkg.sv
// Shared encodings for the fetch PC unit:
// control-transfer select, branch type and PC state.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ = 3'd0,
        PC_BR  = 3'd1,
        PC_J   = 3'd2,
        PC_JR  = 3'd3,
        PC_JRT = 3'd4
    } pc_sel_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LEZ = 3'd2,
        BR_GTZ = 3'd3,
        BR_LTZ = 3'd4,
        BR_GEZ = 3'd5
    } br_type_e;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/br_cmp.sv
// Branch condition evaluator, shared with decode.
// Compares rs against rt or against zero (signed).
module br_cmp
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [2:0]       br_type,
    output logic             cond
);

    logic neg;
    logic zero;

    // evaluate the selected condition; unused codes never take
    always_comb begin
        neg  = rs[WIDTH-1];
        zero = (rs == '0);
        cond = 1'b0;
        case (br_type_e'(br_type))
            BR_EQ:   cond = (rs == rt);
            BR_NE:   cond = (rs != rt);
            BR_LEZ:  cond = neg | zero;
            BR_GTZ:  cond = ~neg & ~zero;
            BR_LTZ:  cond = neg;
            BR_GEZ:  cond = ~neg;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with branch/jump redirect,
// exception entry/return, and a one-deep redirect hold while stalled.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(32'h0000_4180)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc4,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [2:0]       pc_sel,
    input  logic [2:0]       br_type,
    input  logic [15:0]      imm16,
    input  logic [25:0]      imm26,
    input  logic             ctl_valid,
    input  logic             stall,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic             br_taken,
    output logic             pend
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] pc_cur, br_off, br_tgt, j_tgt, target;
    logic             cond, taken;

    br_cmp #(.WIDTH(WIDTH)) u_cmp (
        .rs      (rs),
        .rt      (rt),
        .br_type (br_type),
        .cond    (cond)
    );

    // decode the control transfer into a redirect flag and target
    always_comb begin
        pc_cur = pc4 - WIDTH'(4);
        br_off = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
        br_tgt = pc_cur + br_off;
        j_tgt  = {pc4[WIDTH-1:28], imm26, 2'b00};
        taken  = 1'b0;
        target = pc4;
        case (pc_sel_e'(pc_sel))
            PC_BR: begin
                taken  = cond;
                target = br_tgt;
            end
            PC_J: begin
                taken  = 1'b1;
                target = j_tgt;
            end
            PC_JR: begin
                taken  = 1'b1;
                target = rs;
            end
            PC_JRT: begin
                taken  = ~rs[WIDTH-1];
                target = rt;
            end
            default: begin
                taken  = 1'b0;
                target = pc4;
            end
        endcase
        br_taken = ctl_valid & taken;
    end

    // next PC, held target and state, highest priority first
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        if (exc_req) begin
            pc_d    = EXC_PC;
            state_d = S_RUN;
        end else if (eret) begin
            pc_d    = epc;
            state_d = S_RUN;
        end else if (state_q == S_PEND) begin
            if (stall) begin
                if (br_taken) tgt_d = target;
            end else begin
                pc_d    = tgt_q;
                state_d = S_RUN;
            end
        end else if (stall) begin
            pc_d = pc_cur;
            if (br_taken) begin
                tgt_d   = target;
                state_d = S_PEND;
            end
        end else begin
            pc_d = br_taken ? target : pc4;
        end
    end

    // PC, held target and state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    assign pc   = pc_q;
    assign pend = (state_q == S_PEND);

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed vector table, multi-cycle
// stall/exception sequences and randomized traffic against a model.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc4, rs, rt, epc;
    logic [2:0]  pc_sel, br_type;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic        ctl_valid, stall, exc_req, eret;
    logic [31:0] pc;
    logic        br_taken, pend;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc4, rs, rt;
        logic [2:0]  sel, bt;
        logic [15:0] i16;
        logic [25:0] i26;
        logic        v;
        logic        exp_tk;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[16];

    logic        m_pend;
    logic [31:0] m_pc, m_saved;

    pc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .pc4       (pc4),
        .rs        (rs),
        .rt        (rt),
        .pc_sel    (pc_sel),
        .br_type   (br_type),
        .imm16     (imm16),
        .imm26     (imm26),
        .ctl_valid (ctl_valid),
        .stall     (stall),
        .exc_req   (exc_req),
        .eret      (eret),
        .epc       (epc),
        .pc        (pc),
        .br_taken  (br_taken),
        .pend      (pend)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; exc_req = 0; eret = 0; epc = '0;
        ctl_valid = 0; pc_sel = 0; br_type = 0;
        rs = '0; rt = '0; imm16 = '0; imm26 = '0;
    endtask

    function automatic vec_t mk(
        input logic [31:0] p4, a, b, input logic [2:0] s, t,
        input logic [15:0] i16, input logic [25:0] i26,
        input logic v, tk, input logic [31:0] ep);
        vec_t r;
        r.pc4 = p4; r.rs = a; r.rt = b; r.sel = s; r.bt = t;
        r.i16 = i16; r.i26 = i26; r.v = v;
        r.exp_tk = tk; r.exp_pc = ep;
        return r;
    endfunction

    // reference: redirect decision straight from the arithmetic rules
    function automatic void model(
        input logic [31:0] p4, a, b, input logic [2:0] s, t,
        input logic [15:0] i16, input logic [25:0] i26,
        input logic v, output logic tk, output logic [31:0] tg);
        int sa, sb, off;
        bit c;
        sa = a; sb = b;
        off = $signed(i16);
        off = off * 4;
        case (t)
            3'd0: c = (sa == sb);
            3'd1: c = (sa != sb);
            3'd2: c = (sa <= 0);
            3'd3: c = (sa > 0);
            3'd4: c = (sa < 0);
            3'd5: c = (sa >= 0);
            default: c = 0;
        endcase
        tk = 0;
        tg = p4;
        case (s)
            3'd1: begin tk = c; tg = p4 - 32'd4 + off; end
            3'd2: begin tk = 1; tg = {p4[31:28], i26, 2'b00}; end
            3'd3: begin tk = 1; tg = a; end
            3'd4: begin tk = (sa >= 0); tg = b; end
            default: tk = 0;
        endcase
        tk = tk & v;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'd5;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1;
        idle();
        pc4 = 32'h3004;
        tick();
        reset = 0;
    endtask

    initial begin
        logic        tk;
        logic [31:0] tg;

        tbl[0]  = mk(32'h3010, 32'd5, 32'd5, 3'd1, 3'd0, 16'hFFFE, 26'd0, 1'b1, 1'b1, 32'h3004);
        tbl[1]  = mk(32'h3010, 32'd5, 32'd6, 3'd1, 3'd0, 16'hFFFE, 26'd0, 1'b1, 1'b0, 32'h3010);
        tbl[2]  = mk(32'h3020, 32'hFFFF_FFFF, 32'h3400, 3'd4, 3'd0, 16'd0, 26'd0, 1'b1, 1'b0, 32'h3020);
        tbl[3]  = mk(32'h3020, 32'd0, 32'h3400, 3'd4, 3'd0, 16'd0, 26'd0, 1'b1, 1'b1, 32'h3400);
        tbl[4]  = mk(32'h3010, 32'd0, 32'd0, 3'd2, 3'd0, 16'd0, 26'h0000C40, 1'b1, 1'b1, 32'h3100);
        tbl[5]  = mk(32'h3010, 32'h5000, 32'd0, 3'd3, 3'd0, 16'd0, 26'd0, 1'b1, 1'b1, 32'h5000);
        tbl[6]  = mk(32'h3010, 32'h5000, 32'd0, 3'd2, 3'd0, 16'd0, 26'h0000C40, 1'b0, 1'b0, 32'h3010);
        tbl[7]  = mk(32'h3010, 32'h5000, 32'd0, 3'd5, 3'd0, 16'd0, 26'd0, 1'b1, 1'b0, 32'h3010);
        tbl[8]  = mk(32'h3000, 32'd1, 32'd2, 3'd1, 3'd1, 16'h0004, 26'd0, 1'b1, 1'b1, 32'h300C);
        tbl[9]  = mk(32'h3000, 32'd0, 32'd2, 3'd1, 3'd2, 16'h0001, 26'd0, 1'b1, 1'b1, 32'h3000);
        tbl[10] = mk(32'h3000, 32'd0, 32'd2, 3'd1, 3'd3, 16'h0001, 26'd0, 1'b1, 1'b0, 32'h3000);
        tbl[11] = mk(32'h3000, 32'h8000_0000, 32'd0, 3'd1, 3'd4, 16'h8000, 26'd0, 1'b1, 1'b1, 32'hFFFE_2FFC);
        tbl[12] = mk(32'h3000, 32'h8000_0000, 32'd0, 3'd1, 3'd5, 16'h8000, 26'd0, 1'b1, 1'b0, 32'h3000);
        tbl[13] = mk(32'h3000, 32'd7, 32'd7, 3'd1, 3'd6, 16'h0010, 26'd0, 1'b1, 1'b0, 32'h3000);
        tbl[14] = mk(32'h3000, 32'd7, 32'd7, 3'd0, 3'd0, 16'h0010, 26'd0, 1'b1, 1'b0, 32'h3000);
        tbl[15] = mk(32'hF000_0010, 32'd0, 32'd0, 3'd2, 3'd0, 16'd0, 26'h3FF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFC);

        // reset state; br_taken stays combinational under reset
        reset = 1;
        idle();
        pc4 = 32'h1234;
        pc_sel = 3'd2; ctl_valid = 1;
        tick();
        tick();
        chk("reset_pc", pc, 32'h3000);
        chk("reset_pend", {31'd0, pend}, 32'd0);
        chk("reset_br_taken", {31'd0, br_taken}, 32'd1);

        // sequential fetch after reset
        reset = 0;
        idle();
        pc4 = 32'h3004;
        tick();
        chk("seq_pc1", pc, 32'h3004);
        pc4 = 32'h3008;
        tick();
        chk("seq_pc2", pc, 32'h3008);

        // single-cycle redirect table
        foreach (tbl[i]) begin
            pc4 = tbl[i].pc4; rs = tbl[i].rs; rt = tbl[i].rt;
            pc_sel = tbl[i].sel; br_type = tbl[i].bt;
            imm16 = tbl[i].i16; imm26 = tbl[i].i26;
            ctl_valid = tbl[i].v;
            #1;
            chk($sformatf("tbl%0d_taken", i), {31'd0, br_taken},
                {31'd0, tbl[i].exp_tk});
            tick();
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_pend", i), {31'd0, pend}, 32'd0);
        end

        // jump under stall is held, then released
        do_reset();
        pc4 = 32'h3010; stall = 1;
        pc_sel = 3'd2; imm26 = 26'h0000C40; ctl_valid = 1;
        tick();
        chk("hold_pc", pc, 32'h300C);
        chk("hold_pend", {31'd0, pend}, 32'd1);
        idle();
        stall = 1; pc4 = 32'h3010;
        repeat (2) begin
            tick();
            chk("hold_pc_stalled", pc, 32'h300C);
            chk("hold_pend_stalled", {31'd0, pend}, 32'd1);
        end
        stall = 0;
        pc_sel = 3'd3; rs = 32'h7000; ctl_valid = 1;
        tick();
        chk("release_pc", pc, 32'h3100);
        chk("release_pend", {31'd0, pend}, 32'd0);

        // new redirect while pending overwrites held target
        idle();
        pc4 = 32'h3104; stall = 1;
        pc_sel = 3'd3; rs = 32'h6000; ctl_valid = 1;
        tick();
        rs = 32'h6100;
        tick();
        stall = 0; rs = 32'h6200;
        tick();
        chk("overwrite_pc", pc, 32'h6100);

        // exception beats pending, then eret
        idle();
        pc4 = 32'h3010; stall = 1;
        pc_sel = 3'd2; imm26 = 26'h0000C40; ctl_valid = 1;
        tick();
        chk("pre_exc_pend", {31'd0, pend}, 32'd1);
        exc_req = 1;
        tick();
        chk("exc_pc", pc, 32'h4180);
        chk("exc_pend", {31'd0, pend}, 32'd0);
        exc_req = 0; eret = 1; epc = 32'h3050;
        tick();
        chk("eret_pc", pc, 32'h3050);

        // reset while pending
        idle();
        pc4 = 32'h3010; stall = 1;
        pc_sel = 3'd2; imm26 = 26'h0000C40; ctl_valid = 1;
        tick();
        chk("pre_rst_pend", {31'd0, pend}, 32'd1);
        reset = 1;
        tick();
        chk("rst_pend_pc", pc, 32'h3000);
        chk("rst_pend_pend", {31'd0, pend}, 32'd0);
        reset = 0;
        idle();

        // randomized traffic against the model
        do_reset();
        m_pc = 32'h3000; m_pend = 0; m_saved = '0;
        chk("rand_start_pc", pc, m_pc);
        for (int n = 0; n < 400; n++) begin
            stall   = ($urandom_range(0, 2) == 0);
            exc_req = ($urandom_range(0, 24) == 0);
            eret    = ($urandom_range(0, 24) == 0);
            epc     = $urandom & 32'hFFFF_FFFC;
            pc4     = ($urandom_range(0, 7) == 0) ? $urandom : m_pc + 32'd4;
            rs = pick(); rt = pick();
            pc_sel  = 3'($urandom_range(0, 7));
            br_type = 3'($urandom_range(0, 7));
            imm16   = 16'($urandom);
            imm26   = 26'($urandom);
            ctl_valid = ($urandom_range(0, 4) != 0);
            #1;
            model(pc4, rs, rt, pc_sel, br_type, imm16, imm26, ctl_valid, tk, tg);
            chk("rand_taken", {31'd0, br_taken}, {31'd0, tk});
            if (exc_req) begin
                m_pc = 32'h4180; m_pend = 0;
            end else if (eret) begin
                m_pc = epc; m_pend = 0;
            end else if (m_pend) begin
                if (!stall) begin
                    m_pc = m_saved; m_pend = 0;
                end else if (tk) begin
                    m_saved = tg;
                end
            end else if (stall) begin
                m_pc = pc4 - 32'd4;
                if (tk) begin
                    m_pend = 1; m_saved = tg;
                end
            end else begin
                m_pc = tk ? tg : pc4;
            end
            tick();
            chk("rand_pc", pc, m_pc);
            chk("rand_pend", {31'd0, pend}, {31'd0, m_pend});
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
